// File: rtl/risc_pkg.sv
// Shared definitions for the VeriRISC control unit: opcodes, phase names,
// sequencer state encoding and the ALU-operation classifier used by the
// decoder, the ALU and the disassembler.
package risc_pkg;

    // Opcode encodings (low three bits of the IR opcode field)
    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // Instruction phase encodings
    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Opcodes that read an operand from memory and load the accumulator
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational strobe decoder for the VeriRISC sequencer.
// Ports:
//   i_phase, i_opcode, i_zero, i_state  : decode inputs
//   o_sel .. o_data_e                   : datapath strobes
//   o_halt                              : halt indication (HALTED, or phase 4 of HLT/illegal)
//   o_wait_pt                           : current phase waits for mem_ready
//   o_illegal_op                        : opcode has nonzero bits above bit 2
module risc_ctrl_decode
    import risc_pkg::*;
#(
    parameter int OPC_W = 3
) (
    input  logic [2:0]       i_phase,
    input  logic [OPC_W-1:0] i_opcode,
    input  logic             i_zero,
    input  state_t           i_state,
    output logic             o_sel,
    output logic             o_rd,
    output logic             o_ld_ir,
    output logic             o_inc_pc,
    output logic             o_ld_ac,
    output logic             o_wr,
    output logic             o_ld_pc,
    output logic             o_data_e,
    output logic             o_halt,
    output logic             o_wait_pt,
    output logic             o_illegal_op
);

    logic [OPC_W-1:0] w_hi;
    logic [2:0]       w_op3;
    logic             w_legal;
    logic             w_alu;
    logic             w_hlt;
    logic             w_skz;
    logic             w_sto;
    logic             w_jmp;

    // Legality check and per-opcode flags; illegal codes match no legal opcode
    always_comb begin
        w_hi    = i_opcode >> 3'd3;
        w_op3   = i_opcode[2:0];
        w_legal = (w_hi == {OPC_W{1'b0}});
        w_alu   = w_legal & is_aluop(w_op3);
        w_hlt   = w_legal & (w_op3 == OP_HLT);
        w_skz   = w_legal & (w_op3 == OP_SKZ);
        w_sto   = w_legal & (w_op3 == OP_STO);
        w_jmp   = w_legal & (w_op3 == OP_JMP);
    end

    assign o_illegal_op = ~w_legal;

    // Strobe decode by phase; HALTED forces every strobe low
    always_comb begin
        o_sel     = 1'b0;
        o_rd      = 1'b0;
        o_ld_ir   = 1'b0;
        o_inc_pc  = 1'b0;
        o_ld_ac   = 1'b0;
        o_wr      = 1'b0;
        o_ld_pc   = 1'b0;
        o_data_e  = 1'b0;
        o_halt    = 1'b0;
        o_wait_pt = 1'b0;
        if (i_state == ST_HALTED) begin
            o_halt = 1'b1;
        end else begin
            case (i_phase)
                PH_INST_ADDR: begin
                    o_sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    o_sel = 1'b1;
                    o_rd  = 1'b1;
                end
                PH_INST_LOAD: begin
                    o_sel     = 1'b1;
                    o_rd      = 1'b1;
                    o_ld_ir   = 1'b1;
                    o_wait_pt = 1'b1;
                end
                PH_IDLE: begin
                    o_sel   = 1'b1;
                    o_rd    = 1'b1;
                    o_ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    o_inc_pc = 1'b1;
                    o_halt   = w_hlt | ~w_legal;
                end
                PH_OP_FETCH: begin
                    o_rd = w_alu;
                end
                PH_ALU_OP: begin
                    o_rd      = w_alu;
                    o_inc_pc  = w_skz & i_zero;
                    o_ld_pc   = w_jmp;
                    o_data_e  = w_sto;
                    o_wait_pt = w_alu;
                end
                PH_STORE: begin
                    o_rd      = w_alu;
                    o_ld_ac   = w_alu;
                    o_ld_pc   = w_jmp;
                    o_data_e  = w_sto;
                    o_wr      = w_sto;
                    o_wait_pt = w_sto;
                end
                default: begin
                    o_sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/risc_sequencer.sv
// VeriRISC control unit: phase counter, wait-state/timeout handling, halt,
// resume, single-step and illegal-opcode trapping.
// Ports:
//   i_clk, i_rst (async active-high), i_run, i_step_mode, i_mem_ready,
//   i_zero, i_opcode[OPC_W]
//   o_phase[3], datapath strobes o_sel/o_rd/o_ld_ir/o_inc_pc/o_ld_ac/o_wr/
//   o_ld_pc/o_data_e, o_halt, sticky o_illegal and o_timeout
module risc_sequencer
    import risc_pkg::*;
#(
    parameter int OPC_W    = 3,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_step_mode,
    input  logic             i_mem_ready,
    input  logic             i_zero,
    input  logic [OPC_W-1:0] i_opcode,
    output logic [2:0]       o_phase,
    output logic             o_sel,
    output logic             o_rd,
    output logic             o_ld_ir,
    output logic             o_inc_pc,
    output logic             o_ld_ac,
    output logic             o_wr,
    output logic             o_ld_pc,
    output logic             o_data_e,
    output logic             o_halt,
    output logic             o_illegal,
    output logic             o_timeout
);

    localparam logic TIMEOUT_EN = (MAX_WAIT != 32'sd0);

    state_t           r_state;
    logic [2:0]       r_phase;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_illegal;
    logic             r_timeout;
    logic             w_halt;
    logic             w_wait_pt;
    logic             w_illegal_op;

    risc_ctrl_decode #(.OPC_W(OPC_W)) u_decode (
        .i_phase      (r_phase),
        .i_opcode     (i_opcode),
        .i_zero       (i_zero),
        .i_state      (r_state),
        .o_sel        (o_sel),
        .o_rd         (o_rd),
        .o_ld_ir      (o_ld_ir),
        .o_inc_pc     (o_inc_pc),
        .o_ld_ac      (o_ld_ac),
        .o_wr         (o_wr),
        .o_ld_pc      (o_ld_pc),
        .o_data_e     (o_data_e),
        .o_halt       (w_halt),
        .o_wait_pt    (w_wait_pt),
        .o_illegal_op (w_illegal_op)
    );

    assign o_halt    = w_halt;
    assign o_phase   = r_phase;
    assign o_illegal = r_illegal;
    assign o_timeout = r_timeout;

    // Sequencer FSM: phase counter, wait counter and sticky error flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_RUN;
            r_phase    <= 3'd0;
            r_wait_cnt <= {CNT_W{1'b0}};
            r_illegal  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if ((r_phase == PH_OP_ADDR) && w_illegal_op) begin
                        r_illegal <= 1'b1;
                    end
                    // w_halt in RUN is only ever the phase-4 HLT/illegal event
                    if (w_halt) begin
                        r_state <= ST_HALTED;
                        r_phase <= 3'd0;
                    end else if (w_wait_pt && !i_mem_ready) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= {CNT_W{1'b0}};
                    end else if ((r_phase == PH_STORE) && i_step_mode) begin
                        r_state <= ST_HALTED;
                        r_phase <= 3'd0;
                    end else begin
                        r_phase <= r_phase + 3'd1;
                    end
                end
                ST_WAIT: begin
                    if (i_mem_ready) begin
                        r_wait_cnt <= {CNT_W{1'b0}};
                        if ((r_phase == PH_STORE) && i_step_mode) begin
                            r_state <= ST_HALTED;
                            r_phase <= 3'd0;
                        end else begin
                            r_state <= ST_RUN;
                            r_phase <= r_phase + 3'd1;
                        end
                    end else if (TIMEOUT_EN && (r_wait_cnt == CNT_W'(MAX_WAIT))) begin
                        r_timeout  <= 1'b1;
                        r_state    <= ST_HALTED;
                        r_phase    <= 3'd0;
                        r_wait_cnt <= {CNT_W{1'b0}};
                    end else begin
                        r_wait_cnt <= r_wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_HALTED: begin
                    r_phase <= 3'd0;
                    if (i_run) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_HALTED;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_phase <= 3'd0;
                end
            endcase
        end
    end

endmodule
